// File: rtl/axis_framer.sv
// -----------------------------------------------------------------------------
// axis_framer
//
// Takes raw pixel beats from an unframed valid/ready input and re-emits them as
// a framed Axis master stream. The frame dimensions are captured when a frame
// starts. m_sof marks the first pixel of the frame and m_eol marks the last
// pixel of every line. A single registered output stage sits between input and
// output. It sustains one beat per cycle and honours downstream backpressure.
//
// Parameters
//   DataWidth  pixel width
//   ColWidth   width of the column count / column counter
//   RowWidth   width of the row count / row counter
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start       one-cycle frame request, honoured only while idle
//   cols, rows  frame dimensions, captured on an accepted start
//   s_data      input pixel
//   s_valid     input beat valid
//   s_ready     input beat accepted when s_valid && s_ready
//   m_data      output pixel
//   m_valid     output beat valid
//   m_ready     downstream ready
//   m_sof       first pixel of the frame (qualified by m_valid)
//   m_eol       last pixel of a line (qualified by m_valid)
//   busy        high from accepted start until the last output beat transfers
//   frame_done  one-cycle pulse after the last beat of the frame transfers
// -----------------------------------------------------------------------------
module axis_framer #(
  parameter int DataWidth = 8,
  parameter int ColWidth  = 12,
  parameter int RowWidth  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ColWidth-1:0]  cols,
  input  logic [RowWidth-1:0]  rows,
  input  logic [DataWidth-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Frame dimensions captured at start, plus the position of the next input pixel.
  logic [ColWidth-1:0] cols_l;
  logic [RowWidth-1:0] rows_l;
  logic [ColWidth-1:0] col;
  logic [RowWidth-1:0] row;

  // Last column and last row indices. Zero dimensions never reach here, so
  // subtracting one cannot wrap.
  logic [ColWidth-1:0] col_max;
  logic [RowWidth-1:0] row_max;

  logic start_ok;
  logic in_hs;
  logic out_hs;
  logic pix_sof;
  logic pix_eol;
  logic pix_last;

  assign col_max  = cols_l - ColWidth'(1);
  assign row_max  = rows_l - RowWidth'(1);

  assign start_ok = start && (cols != '0) && (rows != '0);
  assign in_hs    = s_valid && s_ready;
  assign out_hs   = m_valid && m_ready;

  // Framing flags for the pixel that is currently presented at the input.
  assign pix_sof  = (col == '0) && (row == '0);
  assign pix_eol  = (col == col_max);
  assign pix_last = pix_eol && (row == row_max);

  // ---------------------------------------------------------------------------
  // Next-state logic and input ready
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement.
  // Without those defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_next = RUN;
      end
      RUN: begin
        // The output register can take a new beat when it is empty or is
        // being emptied in this same cycle.
        s_ready = !m_valid || m_ready;
        if (s_valid && (!m_valid || m_ready) && pix_last) state_next = DRAIN;
      end
      DRAIN: begin
        // Only the frame's final beat can still be in the output register here.
        if (out_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // This keeps every flop sampling its inputs from before the clock edge,
  // whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Dimension latch and pixel position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cols_l <= '0;
      rows_l <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      if ((state == IDLE) && start_ok) begin
        cols_l <= cols;
        rows_l <= rows;
        col    <= '0;
        row    <= '0;
      end else if (in_hs) begin
        if (pix_last) begin
          col <= '0;
          row <= '0;
        end else if (pix_eol) begin
          col <= '0;
          row <= row + RowWidth'(1);
        end else begin
          col <= col + ColWidth'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Data and flags load only on an input handshake. An input handshake cannot
  // happen while the register is stalled, so the outputs stay stable during
  // backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      if (in_hs) begin
        m_data <= s_data;
        m_sof  <= pix_sof;
        m_eol  <= pix_eol;
      end
      // A reload in the same cycle as a transfer keeps m_valid high. This gives
      // back-to-back beats.
      if (in_hs) begin
        m_valid <= 1'b1;
      end else if (out_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if ((state == IDLE) && start_ok) begin
        busy <= 1'b1;
      end else if ((state == DRAIN) && out_hs) begin
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

endmodule
